// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and default payload
// width for the elastic pipeline register.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam int PIPE_W = 32;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_BUSY  = ST_BUSY,
        S_FULL  = ST_FULL
    } pipe_state_t;

endpackage

// File: rtl/pipe_data_reg.sv
// pipe_data_reg: WIDTH-bit payload register with load
// enable and asynchronous clear.
module pipe_data_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: two-entry elastic stage register with
// registered-only outputs and a flush for redirects.
module pipe_skid_buffer
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    pipe_state_t      state_q;
    pipe_state_t      state_d;
    logic             main_ld;
    logic             skid_ld;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;

    assign in_ready  = (state_q != S_FULL);
    assign out_valid = (state_q != S_EMPTY);
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            S_BUSY:  occupancy = 2'd1;
            S_FULL:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_ld = 1'b0;
        skid_ld = 1'b0;
        main_d  = in_data;
        case (state_q)
            S_EMPTY: begin
                if (in_fire) begin
                    state_d = S_BUSY;
                    main_ld = 1'b1;
                end
            end
            S_BUSY: begin
                if (in_fire && out_fire) begin
                    main_ld = 1'b1;
                end else if (in_fire) begin
                    state_d = S_FULL;
                    skid_ld = 1'b1;
                end else if (out_fire) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (out_fire) begin
                    state_d = S_BUSY;
                    main_ld = 1'b1;
                    main_d  = skid_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        // flushed entries keep stale payload; only validity is dropped
        if (flush) begin
            state_d = S_EMPTY;
            main_ld = 1'b0;
            skid_ld = 1'b0;
        end
    end

    pipe_data_reg #(.WIDTH(WIDTH)) u_main (
        .clk (clk),
        .rst (rst),
        .ld  (main_ld),
        .d   (main_d),
        .q   (main_q)
    );

    pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
        .clk (clk),
        .rst (rst),
        .ld  (skid_ld),
        .d   (in_data),
        .q   (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// tb_pipe_skid_buffer: directed and random stimulus
// checked against a queue-based two-entry FIFO model.
module tb_pipe_skid_buffer;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    int n_checks;
    int n_fail;

    logic [31:0] mq[$];

    pipe_skid_buffer #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        int sz;
        sz = mq.size();
        check("out_valid", 32'(out_valid), 32'(sz != 0));
        check("in_ready", 32'(in_ready), 32'(sz < 2));
        check("occupancy", 32'(occupancy), 32'(sz));
        if (sz != 0) begin
            check("out_data", out_data, mq[0]);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_out_data", out_data, 32'd0);
    endtask

    // drive at negedge, model at posedge, compare at next negedge
    task automatic step(
        input logic        fl,
        input logic        iv,
        input logic [31:0] id,
        input logic        ordy
    );
        bit ir;
        bit ov;
        flush     = fl;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        ir = (mq.size() < 2);
        ov = (mq.size() > 0);
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (ov && ordy) void'(mq.pop_front());
            if (iv && ir) mq.push_back(id);
        end
        @(negedge clk);
        check_model();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // 1: reset then single transfer
        @(negedge clk);
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        check("t1_data", out_data, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("t1_empty", 32'(out_valid), 32'd0);

        // 2: streaming
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 32'(i), 1'b1);
            check("t2_data", out_data, 32'(i));
            check("t2_occ_le1", 32'(occupancy <= 2'd1), 32'd1);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // 3: stall and fill
        step(1'b0, 1'b1, 32'hA, 1'b0);
        step(1'b0, 1'b1, 32'hB, 1'b0);
        check("t3_full", 32'(occupancy), 32'd2);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 32'hC, 1'b0);
            check("t3_stable", out_data, 32'hA);
        end
        step(1'b0, 1'b1, 32'hC, 1'b1);
        check("t3_b", out_data, 32'hB);
        step(1'b0, 1'b1, 32'hC, 1'b1);
        check("t3_c", out_data, 32'hC);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // 4: simultaneous in/out while busy
        step(1'b0, 1'b1, 32'h1111_0000, 1'b0);
        step(1'b0, 1'b1, 32'h2222_0000, 1'b1);
        check("t4_occ", 32'(occupancy), 32'd1);
        check("t4_y", out_data, 32'h2222_0000);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // 5: flush while full with concurrent offer
        step(1'b0, 1'b1, 32'h5A, 1'b0);
        step(1'b0, 1'b1, 32'h5B, 1'b0);
        step(1'b1, 1'b1, 32'h5C, 1'b0);
        check("t5_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            check("t5_gone", 32'(out_valid), 32'd0);
        end

        // 6: async reset while full
        step(1'b0, 1'b1, 32'h6A, 1'b0);
        step(1'b0, 1'b1, 32'h6B, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_vals();
        mq.delete();
        #1 rst = 1'b0;
        @(negedge clk);
        check_model();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(15) == 0,
                 1'($urandom_range(1)),
                 $urandom,
                 $urandom_range(3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
